sample_word_unpacker: RTL and testbench

Single-clock unpacker that takes packed 128-bit DDS words in the {I0,I1,I2,I3,Q0,Q1,Q2,Q3} layout and emits one signed I/Q sample pair per clock with valid/ready flow control. It is the read side of the packed-sample interface. It sits between the operations datapath, which consumes words at word rate, and per-sample consumers such as the output DAC path and the checker models. A two-entry word buffer sustains one sample per clock with no bubbles while upstream supplies one word every LANES cycles.

---
 rtl/nmr_stream_pkg.sv | 28 ++
 rtl/sample_word_buf.sv | 57 +++++
 rtl/sample_word_unpacker.sv | 99 +++++++++
 tb/tb_sample_word_unpacker.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nmr_stream_pkg.sv
// Shared packed-sample stream definitions: sample/lane widths and lane slicing.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package nmr_stream_pkg;

  localparam int SAMPLE_W = 16;
  localparam int LANES    = 4;
  localparam int WORD_W   = 2 * LANES * SAMPLE_W;
  localparam int LANE_W   = (LANES > 1) ? $clog2(LANES) : 1;

  // Lane k of the I half. Lane 0 is the most significant lane of the upper half.
  // Shifting first keeps the select constant, so no index-width juggling.
  function automatic logic [SAMPLE_W-1:0] get_i(input logic [WORD_W-1:0] word,
                                                 input logic [LANE_W-1:0] k);
    logic [WORD_W-1:0] sh;
    sh = word << (k * SAMPLE_W);
    return sh[WORD_W-1 -: SAMPLE_W];
  endfunction

  // Lane k of the Q half. Lane 0 is the most significant lane of the lower half.
  function automatic logic [SAMPLE_W-1:0] get_q(input logic [WORD_W-1:0] word,
                                                 input logic [LANE_W-1:0] k);
    logic [WORD_W-1:0] sh;
    sh = word << (k * SAMPLE_W);
    return sh[WORD_W/2-1 -: SAMPLE_W];
  endfunction

endpackage

// File: rtl/sample_word_buf.sv
// Two-entry word holding register (active + pending) with fill/refill priority.
// Latency: a word pushed into an empty buffer is active on the accept edge.
// Backpressure: push_rdy = !pending_vld; refill order on pop_last is pending, push, empty.
module sample_word_buf
  import nmr_stream_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push_vld,
  input  logic [WORD_W-1:0] push_dat,
  output logic              push_rdy,
  input  logic              pop_last,
  output logic [WORD_W-1:0] active_dat,
  output logic              active_vld,
  output logic              pending_vld
);

  logic [WORD_W-1:0] pending_dat;
  logic              push;

  // Ready depends only on state, so upstream can never form a loop through it.
  assign push_rdy = !pending_vld;
  assign push     = push_vld && push_rdy;

  // Active/pending registers; flush outranks every other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_dat  <= '0;
      active_vld  <= 1'b0;
      pending_dat <= '0;
      pending_vld <= 1'b0;
    end else if (flush) begin
      active_vld  <= 1'b0;
      pending_vld <= 1'b0;
    end else if (pop_last) begin
      // Last lane leaving: pending wins, then a word arriving this cycle.
      if (pending_vld) begin
        active_dat  <= pending_dat;
        pending_vld <= 1'b0;
      end else if (push) begin
        active_dat <= push_dat;
      end else begin
        active_vld <= 1'b0;
      end
    end else if (push) begin
      if (!active_vld) begin
        active_dat <= push_dat;
        active_vld <= 1'b1;
      end else begin
        pending_dat <= push_dat;
        pending_vld <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sample_word_unpacker.sv
// Unpacks {I0..I3,Q0..Q3} words into one signed I/Q pair per clock; optional underrun counter (UNPACK_UNDERRUN_EN).
// Latency: a word accepted into an empty unpacker is presented as lane 0 right after the accept edge.
// Backpressure: out_ready low holds the sample; word_ready drops only when active and pending are both full.
module sample_word_unpacker
  import nmr_stream_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WORD_W-1:0]   word_in,
  input  logic                word_valid,
  output logic                word_ready,
  input  logic                flush,
  output logic [SAMPLE_W-1:0] i_out,
  output logic [SAMPLE_W-1:0] q_out,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_first
`ifdef UNPACK_UNDERRUN_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);

  logic [WORD_W-1:0] active_dat;
  logic              active_vld;
  logic              pending_vld;
  logic [LANE_W-1:0] lane;
  logic              last_lane;
  logic              consume;
  logic              pop_last;

  assign last_lane = (lane == LANE_W'(LANES - 1));
  assign consume   = active_vld && out_ready;
  assign pop_last  = consume && last_lane;

  sample_word_buf u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .push_vld    (word_valid),
    .push_dat    (word_in),
    .push_rdy    (word_ready),
    .pop_last    (pop_last),
    .active_dat  (active_dat),
    .active_vld  (active_vld),
    .pending_vld (pending_vld)
  );

  // Lane counter walks the active word and wraps when its last lane is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
    end else if (flush) begin
      lane <= '0;
    end else if (consume) begin
      lane <= last_lane ? '0 : lane + LANE_W'(1);
    end
  end

  // Output mux; samples are forced to zero whenever nothing is valid.
  always_comb begin
    out_valid = active_vld;
    out_first = 1'b0;
    i_out     = '0;
    q_out     = '0;
    if (active_vld) begin
      out_first = (lane == '0);
      i_out     = get_i(active_dat, lane);
      q_out     = get_q(active_dat, lane);
    end
  end

`ifdef UNPACK_UNDERRUN_EN
  logic armed;

  // Underrun counting starts only once the stream has actually delivered a sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed        <= 1'b0;
      underrun_cnt <= '0;
    end else if (flush) begin
      armed        <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (consume) begin
        armed <= 1'b1;
      end
      if (armed && out_ready && !active_vld && (underrun_cnt != 16'hFFFF)) begin
        underrun_cnt <= underrun_cnt + 16'd1;
      end
    end
  end
`endif

  // pending_vld is consumed inside the buffer; it is exported for visibility only.
  logic unused_ok;
  assign unused_ok = pending_vld;

endmodule

// File: tb/tb_sample_word_unpacker.sv
// Scoreboard bench for sample_word_unpacker: directed words, expected pairs queued on accept.
// Latency: monitor samples on the falling edge, away from the active edge.
// Backpressure: exercised by holding out_ready low while three words are offered.
module tb_sample_word_unpacker;
  import nmr_stream_pkg::*;

  logic                clk;
  logic                rst_n;
  logic [WORD_W-1:0]   word_in;
  logic                word_valid;
  logic                word_ready;
  logic                flush;
  logic [SAMPLE_W-1:0] i_out;
  logic [SAMPLE_W-1:0] q_out;
  logic                out_valid;
  logic                out_ready;
  logic                out_first;
`ifdef UNPACK_UNDERRUN_EN
  logic [15:0]         underrun_cnt;
`endif

  int          errors;
  int          checks;
  int          n_acc;
  int          gaps;
  bit          gap_chk;
  logic [32:0] exp_q[$];

  sample_word_unpacker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .flush        (flush),
    .i_out        (i_out),
    .q_out        (q_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_first    (out_first)
`ifdef UNPACK_UNDERRUN_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word layout written out explicitly: I0..I3 then Q0..Q3, lane 0 first.
  function automatic logic [WORD_W-1:0] mk_word(input logic [15:0] bi, input logic [15:0] bq);
    return {bi, 16'(bi + 16'd1), 16'(bi + 16'd2), 16'(bi + 16'd3),
            bq, 16'(bq - 16'd1), 16'(bq - 16'd2), 16'(bq - 16'd3)};
  endfunction

  task automatic push_lanes(input logic [15:0] bi, input logic [15:0] bq, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back({(k == 0), 16'(bi + 16'(k)), 16'(bq - 16'(k))});
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Offer one word; called and returns at 1 time unit after a rising edge.
  task automatic send_word(input logic [15:0] bi, input logic [15:0] bq);
    int t;
    bit ok;
    word_in    = mk_word(bi, bq);
    word_valid = 1'b1;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (word_ready) ok = 1'b1;
      t++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_word_timeout: got word_ready=0 expected 1 within 200 cycles");
    end else begin
      push_lanes(bi, bq, 4);
      n_acc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_remaining", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [32:0] snap;
    int          bad;
    int          t;

    errors     = 0;
    checks     = 0;
    n_acc      = 0;
    gaps       = 0;
    gap_chk    = 1'b0;
    rst_n      = 1'b0;
    word_in    = '0;
    word_valid = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b0;

    // Scoreboard monitor: every consumed sample must match the head of the queue.
    fork
      forever begin
        @(negedge clk);
        if (rst_n && !flush && out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sample: got i=%h q=%h first=%b expected no sample",
                     i_out, q_out, out_first);
          end else begin
            logic [32:0] e;
            e = exp_q.pop_front();
            if ({out_first, i_out, q_out} !== e) begin
              errors++;
              $display("FAIL sample: got first=%b i=%h q=%h expected first=%b i=%h q=%h",
                       out_first, i_out, q_out, e[32], e[31:16], e[15:0]);
            end
          end
        end
        if (gap_chk && exp_q.size() != 0 && !out_valid) gaps++;
      end
    join_none

    // Reset state
    #12;
    chk("rst_word_ready", 32'(word_ready), 32'd1);
    chk("rst_out_valid",  32'(out_valid),  32'd0);
    chk("rst_out_first",  32'(out_first),  32'd0);
    chk("rst_i_out",      32'(i_out),      32'd0);
    chk("rst_q_out",      32'(q_out),      32'd0);
`ifdef UNPACK_UNDERRUN_EN
    chk("rst_underrun",   32'(underrun_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word: (1,-1) (2,-2) (3,-3) (4,-4)
    out_ready = 1'b1;
    send_word(16'h0001, 16'hFFFF);
    word_valid = 1'b0;
    drain();
    chk("single_idle_valid", 32'(out_valid), 32'd0);

    // Back-to-back streaming of 8 words
    for (int w = 0; w < 8; w++) begin
      send_word(16'(16'h1000 + 16'(w) * 16'h0010), 16'(16'h2000 + 16'(w) * 16'h0010));
      if (w == 0) gap_chk = 1'b1;
    end
    word_valid = 1'b0;
    drain();
    gap_chk = 1'b0;
    chk("stream_gaps", 32'(gaps), 32'd0);

    // Backpressure: three words offered while out_ready is held low
    out_ready = 1'b0;
    n_acc     = 0;
    fork
      begin
        send_word(16'h5000, 16'h6000);
        send_word(16'h5100, 16'h6100);
        send_word(16'h5200, 16'h6200);
        word_valid = 1'b0;
      end
      begin
        t = 0;
        while (!out_valid && t < 50) begin
          @(negedge clk);
          t++;
        end
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        chk("bp_first_i", 32'(i_out), 32'h5000);
        snap = {out_first, i_out, q_out};
        bad  = 0;
        repeat (10) begin
          @(negedge clk);
          if (!out_valid || {out_first, i_out, q_out} !== snap) bad++;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        chk("bp_word_ready", 32'(word_ready), 32'd0);
        chk("bp_accepted", 32'(n_acc), 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush at lane 2 with a pending word and a word offered in the flush cycle
    chk("fl_ready_before", 32'(word_ready), 32'd1);
    word_in    = mk_word(16'h3000, 16'h4000);
    word_valid = 1'b1;
    push_lanes(16'h3000, 16'h4000, 2);
    @(posedge clk);
    #1;
    word_in = mk_word(16'h3100, 16'h4100);
    @(posedge clk);
    #1;
    word_in = mk_word(16'h3200, 16'h4200);
    @(posedge clk);
    #1;
    chk("fl_lane2_i", 32'(i_out), 32'h3002);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush      = 1'b0;
    word_valid = 1'b0;
    chk("fl_out_valid", 32'(out_valid), 32'd0);
    chk("fl_word_ready", 32'(word_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("fl_dropped_word", 32'(out_valid), 32'd0);
    chk("fl_queue", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset at lane 1
    word_in    = mk_word(16'h0A00, 16'h0B00);
    word_valid = 1'b1;
    push_lanes(16'h0A00, 16'h0B00, 1);
    @(posedge clk);
    #1;
    word_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rs_lane1_i", 32'(i_out), 32'h0A01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_out_first", 32'(out_first), 32'd0);
    chk("rs_i_out",     32'(i_out),     32'd0);
    chk("rs_q_out",     32'(q_out),     32'd0);
    chk("rs_word_ready", 32'(word_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

`ifdef UNPACK_UNDERRUN_EN
    // Underrun: one word, then five idle cycles with out_ready high
    out_ready = 1'b1;
    send_word(16'h0C00, 16'h0D00);
    word_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("ur_count", 32'(underrun_cnt), 32'd5);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("ur_flush_clear", 32'(underrun_cnt), 32'd0);
`endif

    chk("end_queue", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
